dds_sweep_ctrl: RTL

//  Sequencer for the 32-bit accumulator/sine-ROM function generator: drives its frequency

---
 rtl/dds_sweep_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency-word sequencer for the accumulator/sine-ROM generator.
// Produces one-shot, sawtooth, triangle sweeps or a fixed tone on M, configured via a valid/ready port.
module dds_sweep_ctrl #(
    parameter int WIDTH   = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   f_start,
    input  logic [WIDTH-1:0]   f_stop,
    input  logic [WIDTH-1:0]   f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [1:0]         mode,
    input  logic               start,
    input  logic               abort,
    output logic [WIDTH-1:0]   M,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_SAW     = 2'd1;
    localparam logic [1:0] MODE_TRI     = 2'd2;
    localparam logic [1:0] MODE_CW      = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state_reg, w_state_next;

    // Shadow config, written by the handshake
    logic [WIDTH-1:0]     r_sh_start_reg, w_sh_start_next;
    logic [WIDTH-1:0]     r_sh_stop_reg,  w_sh_stop_next;
    logic [WIDTH-1:0]     r_sh_step_reg,  w_sh_step_next;
    logic [DWELL_W-1:0]   r_sh_dwell_reg, w_sh_dwell_next;
    logic [1:0]           r_sh_mode_reg,  w_sh_mode_next;

    // Working config, frozen for the duration of a sweep
    logic [WIDTH-1:0]     r_wk_start_reg, w_wk_start_next;
    logic [WIDTH-1:0]     r_wk_stop_reg,  w_wk_stop_next;
    logic [WIDTH-1:0]     r_wk_step_reg,  w_wk_step_next;
    logic [DWELL_W-1:0]   r_wk_dwell_reg, w_wk_dwell_next;
    logic [1:0]           r_wk_mode_reg,  w_wk_mode_next;

    logic                 r_dir_down_reg, w_dir_down_next;
    logic [DWELL_W-1:0]   r_dwell_cnt_reg, w_dwell_cnt_next;
    logic [WIDTH-1:0]     r_m_reg, w_m_next;
    logic                 r_busy_reg, w_busy_next;
    logic                 r_done_reg, w_done_next;
    logic                 r_err_reg, w_err_next;
    logic                 r_cfg_ready_reg, w_cfg_ready_next;

    logic                 w_accept;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_up_val;
    logic [WIDTH-1:0]     w_down_val;
    logic [WIDTH-1:0]     w_span_down;

    assign w_accept = cfg_valid & r_cfg_ready_reg;

    // Saturating neighbours of the current M; also serve the turn-around points
    // because M equals the boundary there.
    assign w_sum       = {1'b0, r_m_reg} + {1'b0, r_wk_step_reg};
    assign w_up_val    = (w_sum > {1'b0, r_wk_stop_reg}) ? r_wk_stop_reg : w_sum[WIDTH-1:0];
    assign w_span_down = r_m_reg - r_wk_start_reg;
    assign w_down_val  = (w_span_down <= r_wk_step_reg) ? r_wk_start_reg
                                                        : (r_m_reg - r_wk_step_reg);

    always_comb begin
        w_state_next     = r_state_reg;
        w_sh_start_next  = r_sh_start_reg;
        w_sh_stop_next   = r_sh_stop_reg;
        w_sh_step_next   = r_sh_step_reg;
        w_sh_dwell_next  = r_sh_dwell_reg;
        w_sh_mode_next   = r_sh_mode_reg;
        w_wk_start_next  = r_wk_start_reg;
        w_wk_stop_next   = r_wk_stop_reg;
        w_wk_step_next   = r_wk_step_reg;
        w_wk_dwell_next  = r_wk_dwell_reg;
        w_wk_mode_next   = r_wk_mode_reg;
        w_dir_down_next  = r_dir_down_reg;
        w_dwell_cnt_next = r_dwell_cnt_reg;
        w_m_next         = r_m_reg;
        w_busy_next      = r_busy_reg;
        w_done_next      = 1'b0;
        w_err_next       = 1'b0;

        if (w_accept) begin
            w_sh_start_next = f_start;
            w_sh_stop_next  = f_stop;
            w_sh_step_next  = f_step;
            w_sh_dwell_next = dwell;
            w_sh_mode_next  = mode;
        end

        case (r_state_reg)
            ST_IDLE: begin
                if (abort) begin
                    w_m_next    = '0;
                    w_busy_next = 1'b0;
                end else if (start) begin
                    // Launch uses the shadow as it stood before any same-cycle handshake
                    if (r_sh_start_reg > r_sh_stop_reg) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_wk_start_next  = r_sh_start_reg;
                        w_wk_stop_next   = r_sh_stop_reg;
                        w_wk_step_next   = r_sh_step_reg;
                        w_wk_dwell_next  = r_sh_dwell_reg;
                        w_wk_mode_next   = r_sh_mode_reg;
                        w_m_next         = r_sh_start_reg;
                        w_dir_down_next  = 1'b0;
                        w_dwell_cnt_next = r_sh_dwell_reg;
                        w_busy_next      = 1'b1;
                        w_state_next     = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    w_m_next     = '0;
                    w_busy_next  = 1'b0;
                    w_state_next = ST_IDLE;
                end else if (r_wk_mode_reg == MODE_CW) begin
                    w_m_next = r_m_reg;
                end else if (r_dwell_cnt_reg != '0) begin
                    w_dwell_cnt_next = r_dwell_cnt_reg - 1'b1;
                end else begin
                    w_dwell_cnt_next = r_wk_dwell_reg;
                    // A zero step parks on f_start forever; only abort leaves
                    if (r_wk_step_reg == '0) begin
                        w_m_next = r_m_reg;
                    end else if (!r_dir_down_reg) begin
                        if (r_m_reg == r_wk_stop_reg) begin
                            case (r_wk_mode_reg)
                                MODE_ONESHOT: begin
                                    w_state_next = ST_IDLE;
                                    w_busy_next  = 1'b0;
                                    w_done_next  = 1'b1;
                                end
                                MODE_SAW: w_m_next = r_wk_start_reg;
                                MODE_TRI: begin
                                    w_dir_down_next = 1'b1;
                                    w_m_next        = w_down_val;
                                end
                                default: w_m_next = r_m_reg;
                            endcase
                        end else begin
                            w_m_next = w_up_val;
                        end
                    end else begin
                        if (r_m_reg == r_wk_start_reg) begin
                            w_dir_down_next = 1'b0;
                            w_m_next        = w_up_val;
                        end else begin
                            w_m_next = w_down_val;
                        end
                    end
                end
            end

            default: w_state_next = ST_IDLE;
        endcase

        w_cfg_ready_next = (w_state_next == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_reg     <= ST_IDLE;
            r_sh_start_reg  <= '0;
            r_sh_stop_reg   <= '0;
            r_sh_step_reg   <= '0;
            r_sh_dwell_reg  <= '0;
            r_sh_mode_reg   <= '0;
            r_wk_start_reg  <= '0;
            r_wk_stop_reg   <= '0;
            r_wk_step_reg   <= '0;
            r_wk_dwell_reg  <= '0;
            r_wk_mode_reg   <= '0;
            r_dir_down_reg  <= 1'b0;
            r_dwell_cnt_reg <= '0;
            r_m_reg         <= '0;
            r_busy_reg      <= 1'b0;
            r_done_reg      <= 1'b0;
            r_err_reg       <= 1'b0;
            r_cfg_ready_reg <= 1'b0;
        end else begin
            r_state_reg     <= w_state_next;
            r_sh_start_reg  <= w_sh_start_next;
            r_sh_stop_reg   <= w_sh_stop_next;
            r_sh_step_reg   <= w_sh_step_next;
            r_sh_dwell_reg  <= w_sh_dwell_next;
            r_sh_mode_reg   <= w_sh_mode_next;
            r_wk_start_reg  <= w_wk_start_next;
            r_wk_stop_reg   <= w_wk_stop_next;
            r_wk_step_reg   <= w_wk_step_next;
            r_wk_dwell_reg  <= w_wk_dwell_next;
            r_wk_mode_reg   <= w_wk_mode_next;
            r_dir_down_reg  <= w_dir_down_next;
            r_dwell_cnt_reg <= w_dwell_cnt_next;
            r_m_reg         <= w_m_next;
            r_busy_reg      <= w_busy_next;
            r_done_reg      <= w_done_next;
            r_err_reg       <= w_err_next;
            r_cfg_ready_reg <= w_cfg_ready_next;
        end
    end

    assign M         = r_m_reg;
    assign busy      = r_busy_reg;
    assign done      = r_done_reg;
    assign err       = r_err_reg;
    assign cfg_ready = r_cfg_ready_reg;

endmodule
